// File: rtl/socetlib_fifo_pkg.sv
// rtl/socetlib_fifo_pkg.sv - shared helpers for the parametrised FIFO
//
// Purpose: holds the count-width helper used by the FIFO top for its
//          count/high_water ports.
package socetlib_fifo_pkg;

    // Bits needed to hold 0..d inclusive (occupancy of a d-entry FIFO).
    function automatic int clog2p1(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/socetlib_fifo_mem.sv
// rtl/socetlib_fifo_mem.sv - DEPTH x WIDTH register array, sync write, async read
//
// Purpose: storage for socetlib_fifo_param.
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   we, waddr, wdata   synchronous write port
//   raddr, rdata       combinational read port
module socetlib_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/socetlib_fifo_param.sv
// rtl/socetlib_fifo_param.sv - parametrised first-word-fall-through synchronous FIFO
//
// Purpose: FIFO with configurable width/depth, almost-full/almost-empty
//          thresholds, sticky overrun/underrun flags and a high-water mark.
// Ports:
//   CLK, nRST                   clock (rising edge), asynchronous active-low reset
//   WEN, wdata                  write request and data
//   REN                         read request (pops the head entry)
//   clear                       synchronous flush, overrides WEN/REN
//   rdata                       head entry, always visible
//   full, empty                 count == DEPTH / count == 0
//   almost_full, almost_empty   count >= AF_LEVEL / count <= AE_LEVEL
//   overrun, underrun           sticky error flags
//   count, high_water           occupancy and peak occupancy since reset/clear
module socetlib_fifo_param
    import socetlib_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        WEN,
    input  logic                        REN,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overrun,
    output logic                        underrun,
    output logic [clog2p1(DEPTH)-1:0]   count,
    output logic [clog2p1(DEPTH)-1:0]   high_water
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = clog2p1(DEPTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("socetlib_fifo_param: DEPTH must be a power of 2 and >= 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("socetlib_fifo_param: WIDTH must be >= 1");
        end
    endgenerate

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count_next;
    logic [CW-1:0] high_water_next;
    logic          wr_acc;
    logic          rd_acc;

    // A full FIFO still accepts a write when a read frees the head slot in
    // the same cycle; an empty FIFO never pops, even if a write lands.
    assign wr_acc = WEN && (!full || REN);
    assign rd_acc = REN && !empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            count_next = count - CW'(1);
        end
        high_water_next = (count_next > high_water) ? count_next : high_water;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            high_water <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            high_water <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            count      <= count_next;
            high_water <= high_water_next;
            if (WEN && full && !REN) begin
                overrun <= 1'b1;
            end
            if (REN && empty) begin
                underrun <= 1'b1;
            end
        end
    end

    socetlib_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (wr_acc && !clear),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_socetlib_fifo_param.sv
// tb/tb_socetlib_fifo_param.sv - directed self-checking bench for socetlib_fifo_param
module tb_socetlib_fifo_param;

    logic        CLK;
    logic        nRST;
    logic        WEN;
    logic        REN;
    logic        clear;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overrun;
    logic        underrun;
    logic [2:0]  count;
    logic [2:0]  high_water;

    int vectors;
    int miscompares;

    socetlib_fifo_param #(
        .WIDTH    (16),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .WEN          (WEN),
        .REN          (REN),
        .clear        (clear),
        .wdata        (wdata),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overrun      (overrun),
        .underrun     (underrun),
        .count        (count),
        .high_water   (high_water)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [15:0] d);
        WEN   = w;
        REN   = r;
        clear = c;
        wdata = d;
        @(posedge CLK);
        #1;
        WEN   = 1'b0;
        REN   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".empty"},        32'(empty),        32'd1);
        chk({tag, ".full"},         32'(full),         32'd0);
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, ".almost_full"},  32'(almost_full),  32'd0);
        chk({tag, ".count"},        32'(count),        32'd0);
        chk({tag, ".high_water"},   32'(high_water),   32'd0);
        chk({tag, ".overrun"},      32'(overrun),      32'd0);
        chk({tag, ".underrun"},     32'(underrun),     32'd0);
        chk({tag, ".rdata"},        32'(rdata),        32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST  = 1'b0;
        WEN   = 1'b0;
        REN   = 1'b0;
        clear = 1'b0;
        wdata = '0;

        // Reset asserted from time 0, checked before any clock edge.
        #3;
        chk_reset_state("reset");
        #4;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset_state("idle");

        // Fill with A001..A004.
        cyc(1, 0, 0, 16'hA001);
        chk("w1.count", 32'(count), 32'd1);
        chk("w1.rdata", 32'(rdata), 32'hA001);
        chk("w1.ae",    32'(almost_empty), 32'd1);
        chk("w1.empty", 32'(empty), 32'd0);
        cyc(1, 0, 0, 16'hA002);
        chk("w2.count", 32'(count), 32'd2);
        chk("w2.ae",    32'(almost_empty), 32'd0);
        chk("w2.af",    32'(almost_full), 32'd0);
        cyc(1, 0, 0, 16'hA003);
        chk("w3.count", 32'(count), 32'd3);
        chk("w3.af",    32'(almost_full), 32'd1);
        chk("w3.full",  32'(full), 32'd0);
        cyc(1, 0, 0, 16'hA004);
        chk("w4.count", 32'(count), 32'd4);
        chk("w4.full",  32'(full), 32'd1);
        chk("w4.hw",    32'(high_water), 32'd4);
        chk("w4.rdata", 32'(rdata), 32'hA001);

        // Drain in order.
        chk("p1.rdata", 32'(rdata), 32'hA001);
        cyc(0, 1, 0, 16'h0);
        chk("p2.rdata", 32'(rdata), 32'hA002);
        cyc(0, 1, 0, 16'h0);
        chk("p3.rdata", 32'(rdata), 32'hA003);
        cyc(0, 1, 0, 16'h0);
        chk("p4.rdata", 32'(rdata), 32'hA004);
        cyc(0, 1, 0, 16'h0);
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.count", 32'(count), 32'd0);
        chk("drain.hw",    32'(high_water), 32'd4);

        // Refill, then simultaneous write+read while full.
        cyc(1, 0, 0, 16'hB001);
        cyc(1, 0, 0, 16'hB002);
        cyc(1, 0, 0, 16'hB003);
        cyc(1, 0, 0, 16'hB004);
        chk("refill.full", 32'(full), 32'd1);
        cyc(1, 1, 0, 16'hBEEF);
        chk("fullwr.rdata",   32'(rdata), 32'hB002);
        chk("fullwr.count",   32'(count), 32'd4);
        chk("fullwr.overrun", 32'(overrun), 32'd0);
        cyc(0, 1, 0, 16'h0);
        chk("wrap1.rdata", 32'(rdata), 32'hB003);
        cyc(0, 1, 0, 16'h0);
        chk("wrap2.rdata", 32'(rdata), 32'hB004);
        cyc(0, 1, 0, 16'h0);
        chk("wrap3.rdata", 32'(rdata), 32'hBEEF);
        chk("wrap3.count", 32'(count), 32'd1);
        cyc(0, 1, 0, 16'h0);
        chk("wrap4.empty", 32'(empty), 32'd1);

        // Overrun: write alone while full is dropped.
        cyc(1, 0, 0, 16'hD001);
        cyc(1, 0, 0, 16'hD002);
        cyc(1, 0, 0, 16'hD003);
        cyc(1, 0, 0, 16'hD004);
        chk("ovr.pre", 32'(overrun), 32'd0);
        cyc(1, 0, 0, 16'h1234);
        chk("ovr.overrun", 32'(overrun), 32'd1);
        chk("ovr.count",   32'(count), 32'd4);
        chk("ovr.rdata",   32'(rdata), 32'hD001);
        cyc(0, 1, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        chk("ovr.last", 32'(rdata), 32'hD004);
        cyc(0, 1, 0, 16'h0);
        chk("ovr.empty",  32'(empty), 32'd1);
        chk("ovr.sticky", 32'(overrun), 32'd1);

        // Underrun: read alone while empty.
        chk("unr.pre", 32'(underrun), 32'd0);
        cyc(0, 1, 0, 16'h0);
        chk("unr.underrun", 32'(underrun), 32'd1);
        chk("unr.count",    32'(count), 32'd0);

        // Clear errors, then write+read while empty.
        cyc(0, 0, 1, 16'h0);
        chk("clr1.overrun",  32'(overrun), 32'd0);
        chk("clr1.underrun", 32'(underrun), 32'd0);
        chk("clr1.hw",       32'(high_water), 32'd0);
        cyc(1, 1, 0, 16'h5555);
        chk("ewr.count",    32'(count), 32'd1);
        chk("ewr.rdata",    32'(rdata), 32'h5555);
        chk("ewr.underrun", 32'(underrun), 32'd1);
        chk("ewr.hw",       32'(high_water), 32'd1);

        // Clear with count 3 and a concurrent write.
        cyc(1, 0, 0, 16'h6001);
        cyc(1, 0, 0, 16'h6002);
        chk("pre_clr.count", 32'(count), 32'd3);
        cyc(1, 0, 1, 16'h7777);
        chk("clr2.count",    32'(count), 32'd0);
        chk("clr2.empty",    32'(empty), 32'd1);
        chk("clr2.hw",       32'(high_water), 32'd0);
        chk("clr2.underrun", 32'(underrun), 32'd0);
        chk("clr2.overrun",  32'(overrun), 32'd0);

        // Asynchronous reset in the middle of a write cycle.
        cyc(1, 0, 0, 16'h8001);
        chk("pre_rst.count", 32'(count), 32'd1);
        WEN   = 1'b1;
        wdata = 16'h9999;
        #2;
        nRST = 1'b0;
        #1;
        chk_reset_state("async_rst");
        WEN = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
